// File: rtl/vector_collect.sv
// Deserialises a 4-lane serial frame of NBEATS beats into a 32-bit vector.
// It reports the vector's population count and whether it matches the (size-1)-ones mask.
module vector_collect #(
  parameter int NBEATS = 8
) (
  input  logic        clock,
  input  logic        rst_n,
  input  logic        frame_en,
  input  logic        data_in1,
  input  logic        data_in2,
  input  logic        data_in3,
  input  logic        data_in4,
  input  logic [5:0]  size,
  output logic [31:0] vec_out,
  output logic [5:0]  ones_cnt,
  output logic        mask_ok,
  output logic        vec_valid,
  output logic        frame_err
);

  localparam int CW = (NBEATS > 1) ? $clog2(NBEATS) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] beat_cnt_reg, beat_cnt_next;
  logic [5:0]    size_q_reg, size_q_next;
  logic [31:0]   asm_reg, asm_next;
  logic [31:0]   vec_out_reg, vec_out_next;
  logic [5:0]    ones_cnt_reg, ones_cnt_next;
  logic          mask_ok_reg, mask_ok_next;
  logic          vec_valid_reg, vec_valid_next;
  logic          frame_err_reg, frame_err_next;

  logic [3:0]    lanes;
  logic [CW-1:0] beat_sel;
  logic [31:0]   asm_merged;
  logic [5:0]    size_eff;
  logic [5:0]    mask_len;
  logic [31:0]   exp_mask;
  logic          last_beat;

  function automatic logic [5:0] popcount(input logic [31:0] v);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < 32; i++) begin
      c = c + {5'd0, v[i]};
    end
    return c;
  endfunction

  assign lanes    = {data_in4, data_in3, data_in2, data_in1};
  assign beat_sel = (state_reg == IDLE) ? '0 : beat_cnt_reg;

  // The assembly as it will look once the current beat's lanes are merged in.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_beat
      if (gi < NBEATS) begin : g_used
        assign asm_merged[4*gi +: 4] = (beat_sel == CW'(gi)) ? lanes : asm_reg[4*gi +: 4];
      end else begin : g_unused
        assign asm_merged[4*gi +: 4] = 4'h0;
      end
    end
  endgenerate

  // On the beat-0 edge size_q is not loaded yet, so use the live size input.
  assign size_eff = (state_reg == IDLE) ? size : size_q_reg;
  assign mask_len = size_eff - 6'd1;

  always_comb begin
    exp_mask = 32'h0;
    if (size_eff >= 6'd2 && size_eff <= 6'd33) begin
      exp_mask = 32'hFFFF_FFFF >> (6'd32 - mask_len);
    end
  end

  assign last_beat = ((state_reg == IDLE) && (NBEATS == 1)) ||
                     ((state_reg == SHIFT) && (beat_cnt_reg == CW'(NBEATS - 1)));

  always_comb begin
    state_next     = state_reg;
    beat_cnt_next  = beat_cnt_reg;
    size_q_next    = size_q_reg;
    asm_next       = asm_reg;
    vec_out_next   = vec_out_reg;
    ones_cnt_next  = ones_cnt_reg;
    mask_ok_next   = mask_ok_reg;
    vec_valid_next = 1'b0;
    frame_err_next = 1'b0;

    unique case (state_reg)
      IDLE: begin
        if (frame_en) begin
          asm_next      = asm_merged;
          size_q_next   = size;
          beat_cnt_next = CW'(1);
          state_next    = SHIFT;
        end
      end
      SHIFT: begin
        if (frame_en) begin
          asm_next      = asm_merged;
          beat_cnt_next = beat_cnt_reg + CW'(1);
        end else begin
          asm_next       = '0;
          beat_cnt_next  = '0;
          frame_err_next = 1'b1;
          state_next     = IDLE;
        end
      end
      HOLD: begin
        if (!frame_en) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    if (frame_en && last_beat) begin
      vec_out_next   = asm_merged;
      ones_cnt_next  = popcount(asm_merged);
      mask_ok_next   = (asm_merged == exp_mask);
      vec_valid_next = 1'b1;
      asm_next       = '0;
      beat_cnt_next  = '0;
      state_next     = HOLD;
    end
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      beat_cnt_reg  <= '0;
      size_q_reg    <= '0;
      asm_reg       <= '0;
      vec_out_reg   <= '0;
      ones_cnt_reg  <= '0;
      mask_ok_reg   <= 1'b0;
      vec_valid_reg <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      beat_cnt_reg  <= beat_cnt_next;
      size_q_reg    <= size_q_next;
      asm_reg       <= asm_next;
      vec_out_reg   <= vec_out_next;
      ones_cnt_reg  <= ones_cnt_next;
      mask_ok_reg   <= mask_ok_next;
      vec_valid_reg <= vec_valid_next;
      frame_err_reg <= frame_err_next;
    end
  end

  assign vec_out   = vec_out_reg;
  assign ones_cnt  = ones_cnt_reg;
  assign mask_ok   = mask_ok_reg;
  assign vec_valid = vec_valid_reg;
  assign frame_err = frame_err_reg;

endmodule

// File: tb/tb_vector_collect.sv
// Directed bench for vector_collect: table of full frames plus abort, reset and back-to-back sequences.
module tb_vector_collect;

  logic        clock = 1'b0;
  logic        rst_n;
  logic        frame_en;
  logic        data_in1, data_in2, data_in3, data_in4;
  logic [5:0]  size;
  logic [31:0] vec_out;
  logic [5:0]  ones_cnt;
  logic        mask_ok;
  logic        vec_valid;
  logic        frame_err;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clock = ~clock;

  vector_collect #(.NBEATS(8)) dut (
    .clock    (clock),
    .rst_n    (rst_n),
    .frame_en (frame_en),
    .data_in1 (data_in1),
    .data_in2 (data_in2),
    .data_in3 (data_in3),
    .data_in4 (data_in4),
    .size     (size),
    .vec_out  (vec_out),
    .ones_cnt (ones_cnt),
    .mask_ok  (mask_ok),
    .vec_valid(vec_valid),
    .frame_err(frame_err)
  );

  typedef struct {
    logic [31:0] vec;
    logic [5:0]  sz;
    bit          chg;
    int          hold;
    logic [5:0]  exp_ones;
    bit          exp_ok;
  } vec_t;

  vec_t tbl [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_lanes(input logic [3:0] l);
    {data_in4, data_in3, data_in2, data_in1} = l;
  endtask

  // Sends one full frame, holds frame_en for 'hold' extra zero beats, then drops it for one cycle.
  task automatic send_frame(input string name, input logic [31:0] v, input logic [5:0] sz,
                            input bit chg, input int hold,
                            input logic [5:0] exp_ones, input bit exp_ok);
    int pulses;
    logic [3:0] l;
    pulses = 0;
    for (int b = 0; b < 8; b++) begin
      frame_en = 1'b1;
      l = v[4*b +: 4];
      set_lanes(l);
      if (b == 0) size = sz;
      else if (chg) size = ~sz;
      tick();
      if (vec_valid) pulses++;
      if (b == 7) begin
        check({name, ".valid"}, {31'd0, vec_valid}, 32'd1);
        check({name, ".vec"}, vec_out, v);
        check({name, ".ones"}, {26'd0, ones_cnt}, {26'd0, exp_ones});
        check({name, ".mask_ok"}, {31'd0, mask_ok}, {31'd0, exp_ok});
        check({name, ".err"}, {31'd0, frame_err}, 32'd0);
      end
    end
    set_lanes(4'h0);
    for (int h = 0; h < hold; h++) begin
      tick();
      if (vec_valid) pulses++;
    end
    frame_en = 1'b0;
    tick();
    if (vec_valid) pulses++;
    check({name, ".pulses"}, pulses, 32'd1);
    check({name, ".vec_held"}, vec_out, v);
    $display("[TB] frame %s vec=0x%08h size=%0d -> vec_out=0x%08h ones=%0d mask_ok=%0b",
             name, v, sz, vec_out, ones_cnt, mask_ok);
  endtask

  initial begin
    tbl[0] = '{vec: 32'h0000000F, sz: 6'd5,  chg: 1'b0, hold: 2, exp_ones: 6'd4,  exp_ok: 1'b1};
    tbl[1] = '{vec: 32'hFFFFFFFF, sz: 6'd33, chg: 1'b1, hold: 0, exp_ones: 6'd32, exp_ok: 1'b1};
    tbl[2] = '{vec: 32'h00000005, sz: 6'd3,  chg: 1'b0, hold: 1, exp_ones: 6'd2,  exp_ok: 1'b0};
    tbl[3] = '{vec: 32'h00000000, sz: 6'd1,  chg: 1'b0, hold: 0, exp_ones: 6'd0,  exp_ok: 1'b1};
    tbl[4] = '{vec: 32'h00000000, sz: 6'd0,  chg: 1'b0, hold: 0, exp_ones: 6'd0,  exp_ok: 1'b1};
    tbl[5] = '{vec: 32'h0000000F, sz: 6'd40, chg: 1'b0, hold: 0, exp_ones: 6'd4,  exp_ok: 1'b0};
    tbl[6] = '{vec: 32'h80000001, sz: 6'd2,  chg: 1'b0, hold: 0, exp_ones: 6'd2,  exp_ok: 1'b0};
    tbl[7] = '{vec: 32'h7FFFFFFF, sz: 6'd32, chg: 1'b1, hold: 0, exp_ones: 6'd31, exp_ok: 1'b1};
    tbl[8] = '{vec: 32'h00000001, sz: 6'd2,  chg: 1'b0, hold: 3, exp_ones: 6'd1,  exp_ok: 1'b1};

    rst_n = 1'b0;
    frame_en = 1'b0;
    size = 6'd0;
    set_lanes(4'h0);
    tick();
    tick();
    check("reset.vec", vec_out, 32'd0);
    check("reset.ones", {26'd0, ones_cnt}, 32'd0);
    check("reset.flags", {29'd0, mask_ok, vec_valid, frame_err}, 32'd0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 9; i++) begin
      send_frame($sformatf("tbl%0d", i), tbl[i].vec, tbl[i].sz, tbl[i].chg, tbl[i].hold,
                 tbl[i].exp_ones, tbl[i].exp_ok);
    end

    // Abort after beat 3 keeps the previous vector.
    send_frame("pre_abort", 32'h0000000F, 6'd5, 1'b0, 0, 6'd4, 1'b1);
    for (int b = 0; b < 4; b++) begin
      frame_en = 1'b1;
      set_lanes(4'hA);
      tick();
      check("abort.no_err_early", {31'd0, frame_err}, 32'd0);
    end
    frame_en = 1'b0;
    set_lanes(4'h0);
    tick();
    check("abort.err", {31'd0, frame_err}, 32'd1);
    check("abort.no_valid", {31'd0, vec_valid}, 32'd0);
    check("abort.vec", vec_out, 32'h0000000F);
    check("abort.ones", {26'd0, ones_cnt}, 32'd4);
    check("abort.mask_ok", {31'd0, mask_ok}, 32'd1);
    tick();
    check("abort.err_pulse", {31'd0, frame_err}, 32'd0);
    $display("[TB] abort after beat 3 -> vec_out=0x%08h", vec_out);

    // Reset asserted while beat 5 is on the lanes.
    for (int b = 0; b < 6; b++) begin
      frame_en = 1'b1;
      size = 6'd9;
      set_lanes(4'hF);
      if (b == 5) rst_n = 1'b0;
      tick();
    end
    check("midrst.vec", vec_out, 32'd0);
    check("midrst.ones", {26'd0, ones_cnt}, 32'd0);
    check("midrst.flags", {29'd0, mask_ok, vec_valid, frame_err}, 32'd0);
    rst_n = 1'b1;
    frame_en = 1'b0;
    set_lanes(4'h0);
    tick();
    check("midrst.no_pulse", {30'd0, vec_valid, frame_err}, 32'd0);
    $display("[TB] reset mid-frame -> vec_out=0x%08h", vec_out);
    send_frame("post_rst", 32'h000000FF, 6'd9, 1'b0, 0, 6'd8, 1'b1);

    // Back-to-back frames separated by a single idle cycle.
    send_frame("b2b_a", 32'h00000001, 6'd2, 1'b0, 0, 6'd1, 1'b1);
    send_frame("b2b_b", 32'h00000003, 6'd3, 1'b0, 0, 6'd2, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
